bargraph_peak_hold: RTL and testbench

//  Parametrised successor to the push-button bar graph. Converts a WIDTH-bit

---
 rtl/bargraph_peak_hold_if.sv | 15 +
 rtl/bargraph_peak_hold.sv | 83 ++++++++
 tb/tb_bargraph_peak_hold.sv | 102 ++++++++++
 3 files changed

// File: rtl/bargraph_peak_hold_if.sv
// bargraph_peak_hold_if: level input, display outputs and peak status of the bar graph
interface bargraph_peak_hold_if #(
  parameter int WIDTH = 16
) ();
  localparam int LW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] in;
  logic             dot_mode;
  logic             clear;
  logic [WIDTH-1:0] bar;
  logic [LW-1:0]    level;
  logic [LW-1:0]    peak;
  logic             decaying;
  modport master (output in, dot_mode, clear, input bar, level, peak, decaying);
  modport slave  (input in, dot_mode, clear, output bar, level, peak, decaying);
endinterface

// File: rtl/bargraph_peak_hold.sv
// bargraph_peak_hold: priority-encoded bar/dot display with held, decaying peak marker
module bargraph_peak_hold #(
  parameter int WIDTH       = 16,
  parameter int HOLD_TICKS  = 50,
  parameter int DECAY_TICKS = 10
) (
  input  logic                      hz100,
  input  logic                      reset_n,
  bargraph_peak_hold_if.slave       bus
);
  localparam int LW = $clog2(WIDTH + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int DW = $clog2(DECAY_TICKS + 1);
  typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_t;
  state_t state, state_nx;
  logic [LW-1:0] lvl_nx, peak_q, peak_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [DW-1:0] dec_cnt, dec_nx;
  logic [WIDTH-1:0] bar_nx;
  // level is one past the highest set input bit
  always_comb begin
    lvl_nx = '0;
    for (int i = 0; i < WIDTH; i++) lvl_nx = bus.in[i] ? LW'(i + 1) : lvl_nx;
  end
  // base bar or dot pattern with the next peak position overlaid
  always_comb begin
    bar_nx = '0;
    for (int i = 0; i < WIDTH; i++)
      bar_nx[i] = (bus.dot_mode ? (lvl_nx == LW'(i + 1)) : (lvl_nx > LW'(i))) | (peak_nx == LW'(i + 1));
  end
  // peak FSM: clear wins, then a new peak restarts the hold, else hold/decay timing
  always_comb begin
    state_nx = state;
    peak_nx  = peak_q;
    hold_nx  = hold_cnt;
    dec_nx   = dec_cnt;
    if (bus.clear) begin
      state_nx = IDLE;
      peak_nx  = '0;
      hold_nx  = '0;
      dec_nx   = '0;
    end else if (lvl_nx != '0 && lvl_nx >= peak_q) begin
      state_nx = HOLD;
      peak_nx  = lvl_nx;
      hold_nx  = HW'(HOLD_TICKS - 1);
    end else if (state == HOLD) begin
      state_nx = hold_cnt == '0 ? DECAY : HOLD;
      dec_nx   = hold_cnt == '0 ? DW'(DECAY_TICKS - 1) : dec_cnt;
      hold_nx  = hold_cnt == '0 ? hold_cnt : hold_cnt - HW'(1);
    end else if (state == DECAY) begin
      peak_nx  = dec_cnt == '0 ? peak_q - LW'(1) : peak_q;
      dec_nx   = dec_cnt == '0 ? DW'(DECAY_TICKS - 1) : dec_cnt - DW'(1);
      state_nx = (dec_cnt == '0 && peak_q == LW'(1)) ? IDLE : DECAY;
    end
  end
  // FSM state, peak and counters
  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      peak_q   <= '0;
      hold_cnt <= '0;
      dec_cnt  <= '0;
    end else begin
      state    <= state_nx;
      peak_q   <= peak_nx;
      hold_cnt <= hold_nx;
      dec_cnt  <= dec_nx;
    end
  end
  // registered display outputs
  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      bus.bar      <= '0;
      bus.level    <= '0;
      bus.decaying <= 1'b0;
    end else begin
      bus.bar      <= bar_nx;
      bus.level    <= lvl_nx;
      bus.decaying <= state_nx == DECAY;
    end
  end
  assign bus.peak = peak_q;
endmodule

// File: tb/tb_bargraph_peak_hold.sv
// tb_bargraph_peak_hold: random and directed stimulus against a timing-based peak model
module tb_bargraph_peak_hold;
  localparam int W = 16, H = 4, D = 2;
  logic hz100 = 1'b0;
  logic reset_n;
  bargraph_peak_hold_if #(.WIDTH(W)) bus ();
  bargraph_peak_hold #(.WIDTH(W), .HOLD_TICKS(H), .DECAY_TICKS(D)) dut (
    .hz100(hz100), .reset_n(reset_n), .bus(bus));
  always #5 hz100 = ~hz100;
  int total = 0, bad = 0;
  int p0 = 0, n = 0, e_lvl = 0;
  logic e_dot = 1'b0;
  function automatic int lvl_of(int v);
    int l = 0;
    while ((v >> l) != 0) l++;
    return l;
  endfunction
  function automatic int pk();
    int p;
    if (p0 == 0) return 0;
    if (n < H + D) return p0;
    p = p0 - (n - H) / D;
    return p > 0 ? p : 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    int p = pk();
    int eb = (e_dot ? (e_lvl != 0 ? 1 << (e_lvl - 1) : 0) : (1 << e_lvl) - 1) | (p != 0 ? 1 << (p - 1) : 0);
    chk("level", 32'(bus.level), e_lvl);
    chk("peak", 32'(bus.peak), p);
    chk("bar", 32'(bus.bar), eb & 32'hFFFF);
    chk("decaying", 32'(bus.decaying), (p0 != 0 && n >= H && p > 0) ? 1 : 0);
  endtask
  task automatic step(input logic [15:0] v, input logic dm, input logic cl);
    int l, p;
    @(negedge hz100);
    bus.in = v;
    bus.dot_mode = dm;
    bus.clear = cl;
    @(posedge hz100);
    l = lvl_of(int'(v));
    p = pk();
    if (cl) begin p0 = 0; n = 0; end
    else if (l != 0 && l >= p) begin p0 = l; n = 0; end
    else if (n < 1000) n++;
    e_lvl = l;
    e_dot = dm;
    #1 check_all();
  endtask
  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_bar", 32'(bus.bar), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_peak", 32'(bus.peak), 0);
    chk("rst_decaying", 32'(bus.decaying), 0);
    p0 = 0; n = 0; e_lvl = 0;
    @(posedge hz100);
    #1 reset_n = 1'b1;
  endtask
  initial begin
    bus.in = 16'hFFFF;
    bus.dot_mode = 1'b0;
    bus.clear = 1'b0;
    reset_n = 1'b1;
    #1 reset_pulse();
    step(16'hFFFF, 0, 0);
    repeat (40) step(16'h0000, 0, 0);
    step(16'h0020, 0, 0);
    repeat (20) step(16'h0000, 0, 0);
    step(16'h0104, 1, 0);
    repeat (3) step(16'h0000, 1, 0);
    step(16'h0100, 0, 0);
    repeat (8) step(16'h0000, 0, 0);
    step(16'h0800, 0, 0);
    step(16'h0000, 0, 0);
    step(16'h0200, 0, 0);
    step(16'h0008, 0, 1);
    step(16'h0008, 0, 0);
    repeat (20) step(16'h0004, 0, 0);
    step(16'h0400, 0, 0);
    step(16'h0000, 0, 0);
    reset_pulse();
    step(16'h8000, 0, 0);
    repeat (6) step(16'h0000, 0, 0);
    reset_pulse();
    step(16'h0001, 1, 0);
    repeat (400) begin
      logic [15:0] v;
      v = ($urandom_range(0, 3) == 0) ? 16'(($urandom & 32'hFFFF) >> $urandom_range(0, 15)) : 16'h0000;
      step(v, 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
